// File: rtl/song_player_pkg.sv
// song_player_pkg: game-state codes, song selects, table entry layout and note codes
package song_player_pkg;
  localparam logic [1:0] ST_START = 2'b00, ST_MENU = 2'b01, ST_PLAY = 2'b10, ST_FINISH = 2'b11;
  localparam logic [1:0] SONG_NONE = 2'b00, SONG_1 = 2'b01, SONG_2 = 2'b10, SONG_3 = 2'b11;
  localparam int NOTE_MSB = 7, NOTE_LSB = 4, DUR_MSB = 3, DUR_LSB = 0;
  localparam logic [3:0] END_DUR = 4'd0;
  localparam logic [3:0] NOTE_REST = 4'd0, NOTE_C = 4'd1, NOTE_D = 4'd2, NOTE_E = 4'd3,
                         NOTE_F = 4'd4, NOTE_G = 4'd5, NOTE_A = 4'd6, NOTE_B = 4'd7;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_DONE} fsm_t;
  function automatic logic [7:0] entry(input logic [3:0] n, input logic [3:0] d);
    return {n, d};
  endfunction
endpackage

// File: rtl/song_rom.sv
// song_rom: three song tables, registered read; ports clk, song_sel, addr -> data {note,dur}
module song_rom
  import song_player_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic [1:0]        song_sel,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);
  logic [7:0] s1, s2, s3;
  always_comb begin
    s1 = addr == 0 ? entry(NOTE_C, 4'd2) :
         addr == 1 ? entry(NOTE_REST, 4'd1) :
         addr == 2 ? entry(NOTE_E, 4'd1) : entry(NOTE_REST, END_DUR);
    case (addr)
      0:       s2 = entry(NOTE_G, 4'd2);
      1:       s2 = entry(NOTE_E, 4'd1);
      2:       s2 = entry(NOTE_E, 4'd1);
      3:       s2 = entry(NOTE_F, 4'd2);
      4:       s2 = entry(NOTE_D, 4'd1);
      5:       s2 = entry(NOTE_D, 4'd1);
      6:       s2 = entry(NOTE_C, 4'd3);
      default: s2 = entry(NOTE_REST, END_DUR);
    endcase
    // fills every slot with a one-beat note and no END marker
    s3 = entry(4'(addr), 4'd1);
  end
  always_ff @(posedge clk)
    data <= song_sel == SONG_1 ? s1 : song_sel == SONG_2 ? s2 : song_sel == SONG_3 ? s3 : 8'h00;
endmodule

// File: rtl/song_player.sv
// song_player: plays the selected song table at a fixed beat rate while the game is in PLAY; ports clk, rst, state, song_confirm -> note, note_on, note_idx, finish
module song_player
  import song_player_pkg::*;
#(
  parameter int BEAT_DIV = 12_500_000,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        state,
  input  logic [1:0]        song_confirm,
  output logic [3:0]        note,
  output logic              note_on,
  output logic [ADDR_W-1:0] note_idx,
  output logic              finish
);
  localparam int CW = BEAT_DIV > 1 ? $clog2(BEAT_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
  fsm_t st, n_st;
  logic [1:0] song_sel, n_song_sel;
  logic [ADDR_W-1:0] addr, n_addr, n_note_idx;
  logic [3:0] beats, n_beats, n_note;
  logic [CW-1:0] cnt, n_cnt;
  logic n_note_on, n_finish;
  logic [7:0] rom_data;
  logic [3:0] rom_note, dur;
  logic tick;
  song_rom #(.ADDR_W(ADDR_W)) u_rom (.clk(clk), .song_sel(song_sel), .addr(addr), .data(rom_data));
  assign rom_note = rom_data[NOTE_MSB:NOTE_LSB];
  assign dur = rom_data[DUR_MSB:DUR_LSB];
  assign tick = cnt == CW'(BEAT_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      song_sel <= SONG_NONE;
      addr <= '0;
      beats <= '0;
      cnt <= '0;
      note <= '0;
      note_on <= 1'b0;
      note_idx <= '0;
      finish <= 1'b0;
    end else begin
      st <= n_st;
      song_sel <= n_song_sel;
      addr <= n_addr;
      beats <= n_beats;
      cnt <= n_cnt;
      note <= n_note;
      note_on <= n_note_on;
      note_idx <= n_note_idx;
      finish <= n_finish;
    end
  end
  always_comb begin
    n_st = st;
    n_song_sel = song_sel;
    n_addr = addr;
    n_beats = beats;
    n_cnt = cnt;
    n_note = note;
    n_note_on = note_on;
    n_note_idx = note_idx;
    n_finish = finish;
    // leaving PLAY abandons the song from any active state
    if (st != S_IDLE && state != ST_PLAY) begin
      n_st = S_IDLE;
      n_note = '0;
      n_note_on = 1'b0;
      n_finish = 1'b0;
    end else begin
      case (st)
        S_IDLE: if (state == ST_PLAY) begin
          n_song_sel = song_confirm;
          n_addr = '0;
          n_st = song_confirm == SONG_NONE ? S_DONE : S_FETCH;
          n_finish = song_confirm == SONG_NONE;
        end
        S_FETCH: begin
          n_note_on = 1'b0;
          n_st = S_WAIT;
        end
        S_WAIT: if (dur == END_DUR) begin
          n_st = S_DONE;
          n_note = '0;
          n_note_on = 1'b0;
          n_finish = 1'b1;
        end else begin
          n_note = rom_note;
          n_note_idx = addr;
          n_note_on = rom_note != NOTE_REST;
          n_beats = dur;
          n_cnt = '0;
          n_st = S_HOLD;
        end
        S_HOLD: begin
          n_cnt = tick ? '0 : cnt + CW'(1);
          if (tick) begin
            n_beats = beats - 4'd1;
            if (beats == 4'd1) begin
              n_note_on = 1'b0;
              n_st = addr == LAST ? S_DONE : S_FETCH;
              n_addr = addr == LAST ? addr : addr + ADDR_W'(1);
              n_finish = addr == LAST;
              n_note = addr == LAST ? '0 : note;
            end
          end
        end
        default: begin
          n_note = '0;
          n_note_on = 1'b0;
          n_finish = 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_song_player.sv
// tb_song_player: directed and randomized playback checks against a per-cycle timeline model
module tb_song_player;
  localparam int BD = 4;
  localparam int AW = 6;
  localparam int NMAX = 64;
  logic clk = 0, rst = 1;
  logic [1:0] state = 2'b00, song_confirm = 2'b00;
  logic [3:0] note;
  logic note_on, finish;
  logic [AW-1:0] note_idx;
  int total = 0, bad = 0;
  typedef struct {
    logic on;
    logic [3:0] nt;
    int idx;
    logic fin;
    bit chk_nt;
    bit chk_idx;
  } exp_t;
  exp_t q[$];

  song_player #(.BEAT_DIV(BD), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .state(state), .song_confirm(song_confirm),
    .note(note), .note_on(note_on), .note_idx(note_idx), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] song_entry(input int s, input int i);
    logic [7:0] s1[3], s2[7];
    s1 = '{8'h12, 8'h01, 8'h31};
    s2 = '{8'h52, 8'h31, 8'h31, 8'h42, 8'h21, 8'h21, 8'h13};
    if (s == 1) return i < 3 ? s1[i] : 8'h00;
    if (s == 2) return i < 7 ? s2[i] : 8'h00;
    if (s == 3) return {4'(i % 16), 4'd1};
    return 8'h00;
  endfunction

  function automatic exp_t mk(input logic on, input logic [3:0] nt, input int idx,
                              input logic fin, input bit cn, input bit ci);
    exp_t e;
    e.on = on; e.nt = nt; e.idx = idx; e.fin = fin; e.chk_nt = cn; e.chk_idx = ci;
    return e;
  endfunction

  task automatic build(input int s);
    logic [7:0] e;
    q.delete();
    if (s == 0) begin
      repeat (3) q.push_back(mk(0, 0, 0, 1, 1, 0));
      return;
    end
    repeat (2) q.push_back(mk(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < NMAX; i++) begin
      e = song_entry(s, i);
      if (e[3:0] == 4'd0) begin
        repeat (3) q.push_back(mk(0, 0, 0, 1, 1, 0));
        return;
      end
      repeat (int'(e[3:0]) * BD) q.push_back(mk(e[7:4] != 0, e[7:4], i, 0, 1, 1));
      if (i == NMAX - 1) begin
        repeat (3) q.push_back(mk(0, 0, 0, 1, 1, 0));
        return;
      end
      repeat (2) q.push_back(mk(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic play(input int s, input int toggle_at, input int abort_at);
    exp_t x;
    int k = 0;
    build(s);
    state = 2'b10;
    song_confirm = 2'(s);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      k++;
      x = q.pop_front();
      chk("note_on", 32'(note_on), 32'(x.on));
      chk("finish", 32'(finish), 32'(x.fin));
      if (x.chk_nt) chk("note", 32'(note), 32'(x.nt));
      if (x.chk_idx) chk("note_idx", 32'(note_idx), 32'(x.idx));
      if (k == toggle_at) song_confirm = 2'b11;
      if (k == abort_at) begin
        state = 2'b01;
        @(posedge clk); #1;
        chk("abort_on", 32'(note_on), 0);
        chk("abort_note", 32'(note), 0);
        chk("abort_fin", 32'(finish), 0);
        return;
      end
    end
    state = 2'b11;
    @(posedge clk); #1;
    chk("fin_clear", 32'(finish), 0);
    chk("fin_on", 32'(note_on), 0);
    state = 2'b01;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_note", 32'(note), 0);
    chk("rst_on", 32'(note_on), 0);
    chk("rst_idx", 32'(note_idx), 0);
    chk("rst_fin", 32'(finish), 0);
    rst = 0;
    state = 2'b01;
    @(posedge clk); #1;
    play(1, 0, 0);
    play(0, 0, 0);
    play(1, 0, $urandom_range(4, 20));
    play(1, 0, 0);
    play(1, 6, 0);
    play(3, 0, 0);
    for (int r = 0; r < 6; r++)
      play($urandom_range(1, 2), 0, $urandom_range(0, 1) == 1 ? $urandom_range(3, 25) : 0);
    state = 2'b10;
    song_confirm = 2'b10;
    repeat (12) @(posedge clk);
    #1;
    rst = 1;
    state = 2'b01;
    @(posedge clk); #1;
    chk("mid_rst_note", 32'(note), 0);
    chk("mid_rst_on", 32'(note_on), 0);
    chk("mid_rst_idx", 32'(note_idx), 0);
    chk("mid_rst_fin", 32'(finish), 0);
    rst = 0;
    @(posedge clk); #1;
    play(2, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
